// File: rtl/aes_frame_ctrl_if.sv
// Bundle of the frame sequencer's data and handshake signals.
// slave = sequencer side, master = UART/core/output-stage side.
interface aes_frame_ctrl_if;
    logic [7:0]   rx_byte_in;
    logic         rx_dv_in;
    logic [127:0] key_out;
    logic [127:0] text_out;
    logic         core_start_out;
    logic         core_done_in;
    logic [127:0] core_result_in;
    logic [31:0]  word_out;
    logic         word_dv_out;
    logic         out_done_in;
    logic         busy_out;
    logic         err_timeout_out;

    modport slave (
        input  rx_byte_in,
        input  rx_dv_in,
        output key_out,
        output text_out,
        output core_start_out,
        input  core_done_in,
        input  core_result_in,
        output word_out,
        output word_dv_out,
        input  out_done_in,
        output busy_out,
        output err_timeout_out
    );

    modport master (
        output rx_byte_in,
        output rx_dv_in,
        input  key_out,
        input  text_out,
        input  core_start_out,
        output core_done_in,
        output core_result_in,
        input  word_out,
        input  word_dv_out,
        output out_done_in,
        input  busy_out,
        input  err_timeout_out
    );
endinterface

// File: rtl/aes_frame_ctrl.sv
// AES-128 UART frame sequencer: gathers key+text bytes, runs the core,
// and hands the 128-bit result to the output stage as four 32-bit words.
module aes_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int WORD_GAP       = 2
) (
    input logic             clk,
    input logic             rst_n,
    aes_frame_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (WORD_GAP > 0) ? $clog2(WORD_GAP + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(WORD_GAP);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_TEXT,
        START,
        WAIT_CORE,
        PUSH,
        WAIT_OUT,
        ERROR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    byte_cnt_q;
    logic [3:0]    byte_cnt_d;
    logic [1:0]    word_cnt_q;
    logic [1:0]    word_cnt_d;
    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_d;
    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;
    logic          err_q;
    logic          err_d;
    logic          start_q;
    logic [127:0]  key_q;
    logic [127:0]  text_q;
    logic [127:0]  res_q;
    logic          key_we;
    logic          text_we;
    logic          res_we;
    logic          push;

    // Next-state, counter updates and register write enables.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        key_we     = 1'b0;
        text_we    = 1'b0;
        res_we     = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE, ERROR: begin
                // byte_cnt is always 0 here, so byte 0 lands in [127:120]
                if (bus.rx_dv_in) begin
                    key_we     = 1'b1;
                    err_d      = 1'b0;
                    byte_cnt_d = 4'd1;
                    state_d    = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                if (bus.rx_dv_in) begin
                    key_we     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15) begin
                        state_d = LOAD_TEXT;
                    end
                end
            end
            LOAD_TEXT: begin
                if (bus.rx_dv_in) begin
                    text_we    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_CORE;
            end
            WAIT_CORE: begin
                // done is tested first so it wins over a same-cycle expiry
                if (bus.core_done_in) begin
                    res_we     = 1'b1;
                    word_cnt_d = 2'd0;
                    gap_cnt_d  = '0;
                    state_d    = PUSH;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            PUSH: begin
                // gap phase 0 emits a word, phases 1..WORD_GAP stay idle
                push = (gap_cnt_q == '0);
                if (push && word_cnt_q == 2'd3) begin
                    gap_cnt_d = '0;
                    state_d   = WAIT_OUT;
                end else if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d  = '0;
                    word_cnt_d = word_cnt_q + 2'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            WAIT_OUT: begin
                if (bus.out_done_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, flags and the key/text/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            key_q      <= '0;
            text_q     <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            start_q    <= (state_q == START);
            if (key_we) begin
                key_q[{~byte_cnt_q, 3'b000} +: 8] <= bus.rx_byte_in;
            end
            if (text_we) begin
                text_q[{~byte_cnt_q, 3'b000} +: 8] <= bus.rx_byte_in;
            end
            if (res_we) begin
                res_q <= bus.core_result_in;
            end
        end
    end

    assign bus.key_out         = key_q;
    assign bus.text_out        = text_q;
    assign bus.core_start_out  = start_q;
    assign bus.word_dv_out     = push;
    assign bus.word_out        = push ? res_q[{~word_cnt_q, 5'b00000} +: 32] : 32'd0;
    assign bus.busy_out        = (state_q != IDLE) && (state_q != ERROR);
    assign bus.err_timeout_out = err_q;

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Self-checking bench for aes_frame_ctrl: vector table, corner sequences
// and randomized frames against a byte-level reference model.
module tb_aes_frame_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    aes_frame_ctrl_if bus ();

    aes_frame_ctrl #(
        .TIMEOUT_CYCLES(16),
        .WORD_GAP      (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] text;
        logic [127:0] res;
        int           lat;
        bit           junk;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  frame_b[32];
    logic [31:0] got_words[$];
    int          got_cyc[$];
    int          n_start;
    int          byte_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watch the output side: collect word strobes and start pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.word_dv_out) begin
                got_words.push_back(bus.word_out);
                got_cyc.push_back(cyc);
            end else begin
                n_cmp++;
                if (bus.word_out !== 32'd0) begin
                    n_bad++;
                    $display("FAIL word_idle_zero: got %h expected 0", bus.word_out);
                end
            end
            if (bus.core_start_out) n_start++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte_in = b;
        bus.rx_dv_in   = 1'b1;
        byte_cyc       = cyc;
        @(negedge clk);
        bus.rx_dv_in   = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(frame_b[i]);
    endtask

    task automatic drive_junk(input bit junk);
        if (junk) begin
            bus.rx_dv_in   = 1'($urandom_range(0, 1));
            bus.rx_byte_in = 8'($urandom);
        end
    endtask

    task automatic wait_start(output int start_cyc);
        int n;
        n = 0;
        while (!bus.core_start_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!bus.core_start_out) begin
            n_bad++;
            $display("FAIL start_timeout: got no core_start_out expected pulse");
        end
        start_cyc = cyc;
    endtask

    task automatic run_frame(input logic [127:0] ek, input logic [127:0] et,
                             input logic [127:0] r, input int lat, input bit junk,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        int s_cyc;
        int d_cyc;
        int n;
        logic [31:0] ew[4];
        ew[0] = w0; ew[1] = w1; ew[2] = w2; ew[3] = w3;
        got_words.delete();
        got_cyc.delete();
        n_start = 0;
        send_bytes(32);
        wait_start(s_cyc);
        chk("start_latency", 128'(s_cyc - byte_cyc), 128'd2);
        repeat (lat) begin
            @(negedge clk);
            drive_junk(junk);
        end
        bus.core_done_in   = 1'b1;
        bus.core_result_in = r;
        d_cyc = cyc;
        n = 0;
        while (got_words.size() < 4 && n < 60) begin
            @(negedge clk);
            bus.core_done_in   = 1'b0;
            bus.core_result_in = {4{$urandom}};
            drive_junk(junk);
            n++;
        end
        bus.core_done_in = 1'b0;
        bus.rx_dv_in     = 1'b0;
        @(negedge clk);
        chk("word_count", 128'(got_words.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            if (got_words.size() > i) chk($sformatf("word%0d", i), 128'(got_words[i]), 128'(ew[i]));
        end
        if (got_cyc.size() > 0) chk("done_to_word", 128'(got_cyc[0] - d_cyc), 128'd1);
        for (int i = 0; i < 3; i++) begin
            if (got_cyc.size() > i + 1)
                chk($sformatf("gap%0d", i), 128'(got_cyc[i+1] - got_cyc[i]), 128'd3);
        end
        chk("key", bus.key_out, ek);
        chk("text", bus.text_out, et);
        chk("start_pulses", 128'(n_start), 128'd1);
        chk("err_clear", 128'(bus.err_timeout_out), 128'd0);
        chk("busy_wait_out", 128'(bus.busy_out), 128'd1);
        bus.out_done_in = 1'b1;
        @(negedge clk);
        bus.out_done_in = 1'b0;
        chk("busy_after_done", 128'(bus.busy_out), 128'd0);
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 16; i++) begin
            frame_b[i]      = vecs[v].key[127-8*i -: 8];
            frame_b[i + 16] = vecs[v].text[127-8*i -: 8];
        end
    endtask

    task automatic run_vec(input int v);
        load_vec(v);
        run_frame(vecs[v].key, vecs[v].text, vecs[v].res, vecs[v].lat, vecs[v].junk,
                  vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key"}, bus.key_out, 128'd0);
        chk({tag, "_text"}, bus.text_out, 128'd0);
        chk({tag, "_busy"}, 128'(bus.busy_out), 128'd0);
        chk({tag, "_err"}, 128'(bus.err_timeout_out), 128'd0);
        chk({tag, "_start"}, 128'(bus.core_start_out), 128'd0);
        chk({tag, "_wdv"}, 128'(bus.word_dv_out), 128'd0);
        chk({tag, "_word"}, 128'(bus.word_out), 128'd0);
    endtask

    initial begin
        int s_cyc;
        int n;
        logic [127:0] mk;
        logic [127:0] mt;
        logic [127:0] mr;
        logic [31:0]  mw[4];

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 1'b0,
                    32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
        vecs[1] = '{{16{8'hff}}, 128'd0,
                    128'h0123456789abcdeffedcba9876543210, 0, 1'b1,
                    32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 15, 1'b0,
                    32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
        vecs[3] = '{{16{8'ha5}}, {16{8'h5a}},
                    128'hffffffff00000000aaaaaaaa55555555, 3, 1'b1,
                    32'hffffffff, 32'h00000000, 32'haaaaaaaa, 32'h55555555};

        cyc = 0;
        n_cmp = 0;
        n_bad = 0;
        n_start = 0;
        rst_n = 1'b0;
        bus.rx_byte_in     = '0;
        bus.rx_dv_in       = 1'b0;
        bus.core_done_in   = 1'b0;
        bus.core_result_in = '0;
        bus.out_done_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // core_done and out_done while idle are ignored
        got_words.delete();
        bus.core_done_in   = 1'b1;
        bus.core_result_in = {4{32'hdeadbeef}};
        bus.out_done_in    = 1'b1;
        @(negedge clk);
        bus.core_done_in = 1'b0;
        bus.out_done_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done_busy", 128'(bus.busy_out), 128'd0);
        chk("idle_done_words", 128'(got_words.size()), 128'd0);

        for (int v = 0; v < 4; v++) run_vec(v);

        // core never answers: timeout, then recovery
        load_vec(1);
        got_words.delete();
        send_bytes(32);
        wait_start(s_cyc);
        n = 0;
        while (!bus.err_timeout_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 128'(cyc - s_cyc), 128'd16);
        chk("timeout_err", 128'(bus.err_timeout_out), 128'd1);
        chk("timeout_busy", 128'(bus.busy_out), 128'd0);
        bus.core_done_in   = 1'b1;
        bus.core_result_in = {4{32'h12345678}};
        @(negedge clk);
        bus.core_done_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_done_words", 128'(got_words.size()), 128'd0);
        chk("late_done_err", 128'(bus.err_timeout_out), 128'd1);
        run_vec(0);

        // reset mid-frame after 20 bytes, then a fresh frame
        load_vec(3);
        send_bytes(20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        // randomized frames against the byte-level model
        for (int t = 0; t < 20; t++) begin
            mk = '0;
            mt = '0;
            for (int i = 0; i < 32; i++) frame_b[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) mk = {mk[119:0], frame_b[i]};
            for (int i = 16; i < 32; i++) mt = {mt[119:0], frame_b[i]};
            mr = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) mw[i] = 32'(mr >> (96 - 32 * i));
            run_frame(mk, mt, mr, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                      mw[0], mw[1], mw[2], mw[3]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
